// File: rtl/seq_mult_param.sv
// Radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, unsigned or two's complement per op.
// Latency: start accepted at edge 0, done/p after edge WIDTH; 1 result per WIDTH+1 cycles back-to-back.
// Backpressure: start is accepted only in IDLE/DONE; a start during RUN is dropped silently.
module seq_mult_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mq;
    logic [WIDTH:0]     acc_hi;
    logic [CNT_W-1:0]   count;
    logic               neg;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     acc_nxt;
    logic [WIDTH-1:0]   mq_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               accept;

    always_comb begin
        sum     = acc_hi + (mq[0] ? {1'b0, mcand} : '0);
        acc_nxt = {1'b0, sum[WIDTH:1]};
        mq_nxt  = {sum[0], mq[WIDTH-1:1]};
        prod    = {acc_nxt[WIDTH-1:0], mq_nxt};
        // -(-2^(W-1)) wraps back to 2^(W-1), which is the correct unsigned magnitude
        a_mag   = (signed_mode && a[WIDTH-1]) ? -a : a;
        b_mag   = (signed_mode && b[WIDTH-1]) ? -b : b;
        accept  = start && ((state == IDLE) || (state == DONE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            mq     <= '0;
            acc_hi <= '0;
            count  <= '0;
            neg    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            p      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (accept) begin
                        mcand  <= a_mag;
                        mq     <= b_mag;
                        acc_hi <= '0;
                        count  <= '0;
                        neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    acc_hi <= acc_nxt;
                    mq     <= mq_nxt;
                    count  <= count + CNT_W'(1);
                    if (count == LAST) begin
                        p     <= neg ? -prod : prod;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_param.sv
// Bench for seq_mult_param: WIDTH=8 and WIDTH=16 instances against a cycle-level arithmetic model
// plus directed vectors with literal expected products.
module tb_seq_mult_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st [2];
    logic        sm [2];
    logic [15:0] av [2];
    logic [15:0] bv [2];
    logic        busy_v [2];
    logic        done_v [2];
    logic [15:0] p8;
    logic [31:0] p16;
    logic [31:0] p_v [2];

    int W [2] = '{8, 16};
    int n_chk = 0;
    int n_fail = 0;

    assign p_v[0] = {16'h0, p8};
    assign p_v[1] = p16;

    always #5 clk = ~clk;

    seq_mult_param #(.WIDTH(8)) u_m8 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .signed_mode(sm[0]),
        .a(av[0][7:0]), .b(bv[0][7:0]), .busy(busy_v[0]), .done(done_v[0]), .p(p8)
    );

    seq_mult_param #(.WIDTH(16)) u_m16 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .signed_mode(sm[1]),
        .a(av[1]), .b(bv[1]), .busy(busy_v[1]), .done(done_v[1]), .p(p16)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference product: interpret operands at width w, multiply, wrap to 2w bits.
    function automatic longint ref_mul(int w, bit s, logic [15:0] x, logic [15:0] y);
        longint xa, ya, mask;
        mask = (longint'(1) << w) - 1;
        xa = longint'(x) & mask;
        ya = longint'(y) & mask;
        if (s && xa[w-1]) xa = xa - (longint'(1) << w);
        if (s && ya[w-1]) ya = ya - (longint'(1) << w);
        return (xa * ya) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    // Model: an op accepted on edge e is busy after edges e..e+W-1, done after edge e+W,
    // and a new op may be accepted only on an edge strictly after e+W.
    longint e = 0;
    longint e0 [2] = '{-1000, -1000};
    longint op_end [2] = '{-1000, -1000};
    longint pn [2] = '{0, 0};
    longint ph [2] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                e0[k]     <= -1000;
                op_end[k] <= -1000;
                pn[k]     <= 0;
                ph[k]     <= 0;
            end
        end else begin
            e <= e + 1;
            for (int k = 0; k < 2; k++) begin
                if (st[k] && (e + 1 > op_end[k])) begin
                    ph[k]     <= pn[k];
                    pn[k]     <= ref_mul(W[k], sm[k], av[k], bv[k]);
                    e0[k]     <= e + 1;
                    op_end[k] <= e + 1 + W[k];
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("model_busy[%0d]@%0d", k, e), 64'(busy_v[k]),
                64'((e >= e0[k]) && (e < op_end[k])));
            chk($sformatf("model_done[%0d]@%0d", k, e), 64'(done_v[k]), 64'(e == op_end[k]));
            chk($sformatf("model_p[%0d]@%0d", k, e), 64'(p_v[k]),
                (e >= op_end[k]) ? pn[k] : ph[k]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic issue(input int k, input bit s, input logic [15:0] x, input logic [15:0] y);
        sm[k] = s;
        av[k] = x;
        bv[k] = y;
        st[k] = 1'b1;
        tick();
        st[k] = 1'b0;
    endtask

    task automatic run_op(input int k, input bit s, input logic [15:0] x, input logic [15:0] y,
                          input logic [31:0] exp_p, input string nm);
        int  n = 0;
        int  busy_n = 0;
        bit  seen = 0;
        issue(k, s, x, y);
        while (!seen && n < W[k] + 6) begin
            @(negedge clk);
            n++;
            if (busy_v[k]) busy_n++;
            if (done_v[k]) seen = 1;
        end
        chk({nm, "_done_seen"}, 64'(seen), 64'd1);
        chk({nm, "_latency"}, 64'(n - 1), 64'(W[k]));
        chk({nm, "_busy_cycles"}, 64'(busy_n), 64'(W[k]));
        chk({nm, "_p"}, 64'(p_v[k]), 64'(exp_p));
        tick();
    endtask

    initial begin
        int dn;
        int t1;
        int t2;
        logic [31:0] pcap;
        for (int k = 0; k < 2; k++) begin
            st[k] = 1'b0; sm[k] = 1'b0; av[k] = '0; bv[k] = '0;
        end
        #2;
        chk("reset_busy8", 64'(busy_v[0]), 64'd0);
        chk("reset_done8", 64'(done_v[0]), 64'd0);
        chk("reset_p8", 64'(p8), 64'd0);
        chk("reset_p16", 64'(p16), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // T1: unsigned max, then p held across IDLE while operands wander
        run_op(0, 0, 16'd255, 16'd255, 32'hFE01, "t1_ff_ff");
        av[0] = 16'h12; bv[0] = 16'h34;
        tick(); tick(); tick();
        chk("t1_p_held", 64'(p8), 64'hFE01);
        chk("t1_idle_busy", 64'(busy_v[0]), 64'd0);

        // T2: signed corners and the same bits read unsigned
        run_op(0, 1, 16'h80, 16'h80, 32'h4000, "t2_min_min");
        run_op(0, 1, 16'hFF, 16'h05, 32'hFFFB, "t2_m1_5");
        run_op(0, 0, 16'hFF, 16'h05, 32'h04FB, "t2_u255_5");
        run_op(0, 1, 16'h7F, 16'h80, 32'hC080, "t2_max_min");

        // T3: zero and identity operands still take the full iteration count
        run_op(0, 0, 16'd128, 16'd0, 32'd0, "t3_zero");
        run_op(0, 0, 16'd128, 16'd1, 32'd128, "t3_ident");
        run_op(0, 0, 16'd11, 16'd33, 32'd363, "t3_11_33");

        // T4: start pulses in RUN with new operands must be ignored
        issue(0, 0, 16'd25, 16'd5);
        tick(); tick();
        av[0] = 16'd7; bv[0] = 16'd9; st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        tick(); tick();
        av[0] = 16'd3; bv[0] = 16'd4; st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        dn = 0;
        pcap = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_v[0]) begin dn++; pcap = p_v[0]; end
        end
        chk("t4_done_count", 64'(dn), 64'd1);
        chk("t4_p", 64'(pcap), 64'd125);
        tick();

        // T6: 16-bit instance
        run_op(1, 0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "t6_ffff");
        run_op(1, 1, 16'h8000, 16'h8000, 32'h40000000, "t6_min_min");
        run_op(1, 1, 16'hFFFD, 16'd7, 32'hFFFFFFEB, "t6_m3_7");
        sm[1] = 1'b0; av[1] = 16'd3; bv[1] = 16'd5; st[1] = 1'b1;
        dn = 0; t1 = 0; t2 = 0;
        for (int i = 0; i < 50 && dn < 2; i++) begin
            @(negedge clk);
            if (done_v[1]) begin
                dn++;
                if (dn == 1) t1 = i; else t2 = i;
            end
        end
        st[1] = 1'b0;
        chk("t6_b2b_count", 64'(dn), 64'd2);
        chk("t6_b2b_spacing", 64'(t2 - t1), 64'd17);
        tick(); tick(); tick();
        chk("t6_b2b_p", 64'(p16), 64'd15);

        // T5: asynchronous reset mid-RUN clears outputs at once and kills the op
        issue(0, 0, 16'd25, 16'd7);
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("t5_busy_now", 64'(busy_v[0]), 64'd0);
        chk("t5_done_now", 64'(done_v[0]), 64'd0);
        chk("t5_p8_now", 64'(p8), 64'd0);
        chk("t5_p16_now", 64'(p16), 64'd0);
        tick();
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_v[0]) dn++;
        end
        chk("t5_no_done", 64'(dn), 64'd0);
        tick();
        run_op(0, 0, 16'd36, 16'd36, 32'd1296, "t5_36_36");
        run_op(1, 0, 16'h1234, 16'h0010, 32'h00012340, "t5_w16_after");

        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
